row_pingpong_rf: RTL and testbench

ROW_PINGPONG_RF -- requirements
Module: row_pingpong_rf

---
 rtl/row_pp_pkg.sv | 13 +
 rtl/row_bank.sv | 32 +++
 rtl/row_pingpong_rf.sv | 146 ++++++++++++++
 tb/tb_row_pingpong_rf.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/row_pp_pkg.sv
// Shared types and default sizes for the row ping-pong register file.
package row_pp_pkg;

    localparam int unsigned DefaultDataW    = 64;
    localparam int unsigned DefaultRowWords = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StHold
    } rd_state_e;

endpackage

// File: rtl/row_bank.sv
// One row bank: synchronous write port, asynchronous read mux, cleared on reset.
module row_bank
    import row_pp_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned ROW_WORDS = DefaultRowWords,
    parameter int unsigned ADDR_W    = $clog2(ROW_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [ROW_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROW_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/row_pingpong_rf.sv
// Two-bank row buffer: fill side writes one bank while the read FSM streams the other.
// Optional drop counter built only when ROW_PP_DROP_CNT_EN is defined.
module row_pingpong_rf
    import row_pp_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned ROW_WORDS = DefaultRowWords,
    parameter int unsigned ADDR_W    = $clog2(ROW_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] row_out,
    output logic              row_valid,
    input  logic              row_done,
    output logic [1:0]        bank_full,
    output logic [15:0]       drop_cnt
);

    rd_state_e         state_q, state_d;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0] row_out_q, row_out_d;
    logic              row_valid_q;
    logic              wr_acc, commit_acc, rd_fire, release_row;
    logic [1:0]        bank_we;
    logic [DATA_W-1:0] bank_rdata [2];

    assign wr_ready   = ~bank_full_q[wptr_q];
    assign wr_acc     = wr_en & wr_ready;
    assign commit_acc = wr_commit & wr_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = wr_acc & (wptr_q == 1'(b));

        row_bank #(
            .DATA_W    (DATA_W),
            .ROW_WORDS (ROW_WORDS),
            .ADDR_W    (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we_i    (bank_we[b]),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .raddr_i (rd_idx_q),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        rptr_d      = rptr_q;
        rd_fire     = 1'b0;
        release_row = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bank_full_q[rptr_q]) state_d = StStream;
            end
            StStream: begin
                if (rd_en) begin
                    rd_fire = 1'b1;
                    if (rd_idx_q == ADDR_W'(ROW_WORDS - 1)) begin
                        rd_idx_d = '0;
                        state_d  = StHold;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (row_done) begin
                    release_row = 1'b1;
                    rptr_d      = ~rptr_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Release and commit never target the same bit: a commit needs an empty bank,
    // a release only happens on a full one.
    always_comb begin
        bank_full_d = bank_full_q;
        if (release_row) bank_full_d[rptr_q] = 1'b0;
        if (commit_acc) bank_full_d[wptr_q] = 1'b1;
    end

    assign wptr_d    = commit_acc ? ~wptr_q : wptr_q;
    assign row_out_d = rd_fire ? bank_rdata[rptr_q] : row_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            bank_full_q <= 2'b00;
            rd_idx_q    <= '0;
            row_out_q   <= '0;
            row_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            bank_full_q <= bank_full_d;
            rd_idx_q    <= rd_idx_d;
            row_out_q   <= row_out_d;
            row_valid_q <= rd_fire;
        end
    end

    assign row_out   = row_out_q;
    assign row_valid = row_valid_q;
    assign bank_full = bank_full_q;

`ifdef ROW_PP_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop_evt;

    assign drop_evt = (wr_en | wr_commit) & ~wr_ready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= 16'h0000;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_row_pingpong_rf.sv
// Self-checking bench for row_pingpong_rf: directed scenarios plus random traffic vs a model.
module tb_row_pingpong_rf;

    localparam int unsigned DW = 64;
    localparam int unsigned RW = 4;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_commit = 1'b0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [DW-1:0] row_out;
    logic          row_valid;
    logic          row_done = 1'b0;
    logic [1:0]    bank_full;
    logic [15:0]   drop_cnt;

    row_pingpong_rf #(
        .DATA_W    (DW),
        .ROW_WORDS (RW),
        .ADDR_W    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_commit (wr_commit),
        .wr_ready  (wr_ready),
        .rd_en     (rd_en),
        .row_out   (row_out),
        .row_valid (row_valid),
        .row_done  (row_done),
        .bank_full (bank_full),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: two banks of words, full flags, fill/read bank numbers and a read phase.
    logic [63:0] m_mem [2][RW];
    bit   [1:0]  m_full;
    bit          m_wp, m_rp;
    int          m_ph;     // 0 waiting for a full bank, 1 streaming, 2 waiting for row_done
    int          m_idx;
    logic [63:0] m_out;
    bit          m_valid;
    int          m_drop;

    function automatic logic [15:0] exp_drop(input int n);
`ifdef ROW_PP_DROP_CNT_EN
        return 16'(n);
`else
        return 16'(n - n);
`endif
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < RW; w++) m_mem[b][w] = '0;
        m_full = 2'b00; m_wp = 1'b0; m_rp = 1'b0; m_ph = 0; m_idx = 0;
        m_out = '0; m_valid = 1'b0; m_drop = 0;
    endtask

    task automatic model_step();
        bit       rdy;
        bit [1:0] nf;
        if (rst) begin
            model_reset();
            return;
        end
        rdy     = !m_full[m_wp];
        nf      = m_full;
        m_valid = 1'b0;
        case (m_ph)
            0: if (m_full[m_rp]) m_ph = 1;
            1: if (rd_en) begin
                m_out   = m_mem[m_rp][m_idx];
                m_valid = 1'b1;
                if (m_idx == RW - 1) begin
                    m_idx = 0;
                    m_ph  = 2;
                end else begin
                    m_idx++;
                end
            end
            default: if (row_done) begin
                nf[m_rp] = 1'b0;
                m_rp     = !m_rp;
                m_ph     = 0;
            end
        endcase
        if (wr_en && rdy) m_mem[m_wp][wr_addr] = wr_data;
        if (wr_commit && rdy) begin
            nf[m_wp] = 1'b1;
            m_wp     = !m_wp;
        end
        if ((wr_en || wr_commit) && !rdy && m_drop < 65535) m_drop++;
        m_full = nf;
    endtask

    task automatic check_all();
        check_eq("m_wr_ready", wr_ready, !m_full[m_wp]);
        check_eq("m_row_valid", row_valid, m_valid);
        check_eq("m_row_out", row_out, m_out);
        check_eq("m_bank_full", bank_full, m_full);
        check_eq("m_drop_cnt", drop_cnt, exp_drop(m_drop));
    endtask

    // Inputs are set before the call; they are sampled at the next rising edge then cleared.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; row_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input int a, input logic [63:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_ready", wr_ready, 1'b1);
        check_eq("rst_valid", row_valid, 1'b0);
        check_eq("rst_out", row_out, 64'd0);
        check_eq("rst_full", bank_full, 2'b00);
        check_eq("rst_drop", drop_cnt, 16'd0);
        do_reset();

        // Basic fill, commit, stream of bank0.
        for (int i = 0; i < RW; i++) write_word(i, 64'(i + 1));
        wr_commit = 1'b1; tick();
        check_eq("t1_full", bank_full, 2'b01);
        tick();
        for (int i = 0; i < RW; i++) begin
            rd_en = 1'b1; tick();
            check_eq("t1_valid", row_valid, 1'b1);
            check_eq("t1_out", row_out, 64'(i + 1));
        end
        tick();
        check_eq("t1_valid_off", row_valid, 1'b0);
        check_eq("t1_out_hold", row_out, 64'd4);
        rd_en = 1'b1; tick();
        check_eq("t1_hold_ignores_rd", row_valid, 1'b0);

        // Ping-pong: fill bank1 while bank0 streams.
        do_reset();
        for (int i = 0; i < RW; i++) write_word(i, 64'h10 + 64'(i));
        wr_commit = 1'b1; tick();
        tick();
        for (int i = 0; i < RW; i++) begin
            rd_en = 1'b1;
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 64'h20 + 64'(i);
            tick();
            check_eq("t2_out", row_out, 64'h10 + 64'(i));
            check_eq("t2_ready", wr_ready, 1'b1);
        end
        wr_commit = 1'b1; tick();
        check_eq("t2_ready_low", wr_ready, 1'b0);
        check_eq("t2_full", bank_full, 2'b11);

        // Both full: writes and commit are dropped.
        for (int i = 0; i < 3; i++) write_word(i, 64'hDEAD);
        wr_commit = 1'b1; tick();
        check_eq("t3_drop", drop_cnt, exp_drop(4));
        check_eq("t3_full", bank_full, 2'b11);

        // Release and commit together: release wins, commit is a drop.
        row_done = 1'b1; wr_commit = 1'b1; tick();
        check_eq("t4_full", bank_full, 2'b10);
        check_eq("t4_ready", wr_ready, 1'b1);
        check_eq("t4_drop", drop_cnt, exp_drop(5));
        tick();
        for (int i = 0; i < RW; i++) begin
            rd_en = 1'b1; tick();
            check_eq("t4_bank1_out", row_out, 64'h20 + 64'(i));
        end

        // Same-cycle write and commit; the other words keep their old contents.
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 64'hAA; wr_commit = 1'b1; tick();
        check_eq("t5_full", bank_full, 2'b11);
        row_done = 1'b1; tick();
        tick();
        for (int i = 0; i < RW; i++) begin
            rd_en = 1'b1; tick();
            check_eq("t5_out", row_out, (i == 3) ? 64'hAA : 64'h10 + 64'(i));
        end

        // Reset in the middle of a row.
        for (int i = 0; i < RW; i++) write_word(i, 64'h30 + 64'(i));
        wr_commit = 1'b1; tick();
        row_done = 1'b1; tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            rd_en = 1'b1; tick();
            check_eq("t6_out", row_out, 64'h30 + 64'(i));
        end
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", row_valid, 1'b0);
        check_eq("t6_rst_out", row_out, 64'd0);
        check_eq("t6_rst_full", bank_full, 2'b00);
        check_eq("t6_rst_ready", wr_ready, 1'b1);
        check_eq("t6_rst_drop", drop_cnt, 16'd0);
        model_reset();
        rd_en = 1'b1; tick();
        check_eq("t6_no_pulse", row_valid, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < RW; i++) write_word(i, 64'(i + 5));
        wr_commit = 1'b1; tick();
        tick();
        rd_en = 1'b1; tick();
        check_eq("t6_restart_out", row_out, 64'd5);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = AW'($urandom_range(0, RW - 1));
            wr_data   = {$urandom, $urandom};
            wr_commit = ($urandom_range(0, 7) == 0);
            rd_en     = ($urandom_range(0, 9) < 6);
            row_done  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
